// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode 7-segment display driver.
// Scans NUM_DIGITS hex nibbles one slot at a time (REFRESH_DIV clocks per
// slot), with per-digit decimal points, optional leading-zero blanking,
// PWM brightness control and a one-cycle strobe at the end of every frame.
// All display pins are registered: they follow the current scan index and
// inputs with exactly one clock of latency.
module seven_seg_scan_driver #(
    parameter int  NUM_DIGITS  = 8,
    parameter int  REFRESH_DIV = 100000,
    parameter int  BRIGHT_W    = 4,
    localparam int SEL_W       = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    display_on,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              cathode,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [SEL_W-1:0]        anode_sel,
    output logic                    frame_tick
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);
    localparam logic [6:0]       SEG_OFF  = 7'h7F;

    logic [PRE_W-1:0]      prescaler;
    logic [BRIGHT_W-1:0]   pwm_cnt;
    logic [3:0]            nib_sel;
    logic                  dp_sel;
    logic                  blank_sel;
    logic                  zero_run;
    logic [NUM_DIGITS-1:0] sel_onehot;
    logic                  pwm_on;
    logic [6:0]            seg_sel;

    // Active-low segment pattern {a,b,c,d,e,f,g} for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h01;
            4'h1:    seg = 7'h4F;
            4'h2:    seg = 7'h12;
            4'h3:    seg = 7'h06;
            4'h4:    seg = 7'h4C;
            4'h5:    seg = 7'h24;
            4'h6:    seg = 7'h20;
            4'h7:    seg = 7'h0F;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h04;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h60;
            4'hC:    seg = 7'h31;
            4'hD:    seg = 7'h42;
            4'hE:    seg = 7'h30;
            default: seg = 7'h38;
        endcase
        return seg;
    endfunction

    // Refresh prescaler and scan index; frame_tick marks the wrap back to digit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler  <= '0;
            anode_sel  <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (prescaler == PRE_LAST) begin
                prescaler <= '0;
                if (anode_sel == SEL_LAST) begin
                    anode_sel  <= '0;
                    frame_tick <= 1'b1;
                end else begin
                    anode_sel <= anode_sel + 1'b1;
                end
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    // Free-running PWM phase counter, independent of the scan rate.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Pick the scanned digit; walking from the top digit down, zero_run says
    // whether this digit and everything above it is zero (leading-zero run).
    always_comb begin
        zero_run   = 1'b1;
        nib_sel    = 4'h0;
        dp_sel     = 1'b0;
        blank_sel  = 1'b0;
        sel_onehot = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (digits[4*i +: 4] == 4'h0);
            if (anode_sel == SEL_W'(i)) begin
                nib_sel       = digits[4*i +: 4];
                dp_sel        = dp_in[i];
                blank_sel     = blank_lz && (i != 0) && zero_run;
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // PWM gate and segment pattern for the scanned digit.
    always_comb begin
        pwm_on  = (pwm_cnt <= brightness);
        seg_sel = blank_sel ? SEG_OFF : hex_to_seg(nib_sel);
    end

    // Registered display pins; display_on=0 darkens everything while scanning continues.
    always_ff @(posedge clk) begin
        if (rst || !display_on) begin
            anode   <= '1;
            cathode <= SEG_OFF;
            dp_n    <= 1'b1;
        end else begin
            anode   <= pwm_on ? ~sel_onehot : '1;
            cathode <= seg_sel;
            dp_n    <= ~dp_sel;
        end
    end

endmodule
